// File: rtl/cnn_mac_seq_pkg.sv
// Shared definitions for the CNN MAC sequencer: Q-format widths, tap limit,
// FSM state encoding and the packed result record of the output stage.
package cnn_mac_seq_pkg;

    localparam int FRAC_BITS = 6;   // Q6.6 pixels and result, Q1.6 weights
    localparam int DATA_W    = 12;  // pixel / bias / result width
    localparam int WGT_W     = 7;   // weight width
    localparam int PROD_W    = 20;  // full-precision product, Q.12
    localparam int MAX_TAPS  = 25;  // 5x5 kernel

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic                     ovf;
        logic signed [DATA_W-1:0] val;
    } result_t;

endpackage

// File: rtl/cnn_mac_mul_12s_7s.sv
// Registered signed 12x7 multiplier with one cycle of latency; the single
// output register is meant to land inside the DSP slice.
module cnn_mac_mul_12s_7s
    import cnn_mac_seq_pkg::*;
(
    input  logic                     clk,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [WGT_W-1:0]  b,
    output logic signed [PROD_W-1:0] p
);

    // Product register, no reset: pure datapath.
    always_ff @(posedge clk) begin
        p <= PROD_W'(a) * PROD_W'(b);
    end

endmodule

// File: rtl/cnn_mac_seq.sv
// Sequential multiply-accumulate for one CNN output pixel: streams up to
// MAX_TAPS pixel/weight pairs from two latency-1 memories, accumulates the
// Q.12 products, adds the bias, rescales to Q6.6, applies optional ReLU and
// saturates. Block-level ap_start/ap_done handshake.
module cnn_mac_seq #(
    parameter int MAX_TAPS = cnn_mac_seq_pkg::MAX_TAPS,
    parameter int ACC_W    = 26
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [4:0]         n_taps,
    input  logic               relu_en,
    input  logic signed [11:0] bias,
    output logic [4:0]         x_address0,
    output logic               x_ce0,
    input  logic signed [11:0] x_q0,
    output logic [4:0]         w_address0,
    output logic               w_ce0,
    input  logic signed [6:0]  w_q0,
    output logic signed [11:0] ap_return,
    output logic               ovf
);

    import cnn_mac_seq_pkg::*;

    // Bias is added one bit wider than the accumulator, then the fraction is dropped.
    localparam int SUM_W = ACC_W + 1;
    localparam int R_W   = SUM_W - FRAC_BITS;
    localparam logic signed [R_W-1:0] R_MAX = R_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [R_W-1:0] R_MIN = R_W'(-(2 ** (DATA_W - 1)));

    state_t                    state, state_nxt;
    logic [4:0]                n_clamp, n_eff_r, tap_cnt;
    logic                      drain_cnt;
    logic                      start_acc, last_drain;
    logic                      vld_p0, vld_p1, vld_p2;
    logic                      relu_r;
    logic signed [DATA_W-1:0]  bias_r;
    logic signed [PROD_W-1:0]  prod_p2;
    logic signed [ACC_W-1:0]   acc, acc_nxt;
    result_t                   res;

    // Q.12 accumulator plus Q6.6 bias, floored back to Q6.6 (still unsaturated).
    function automatic logic signed [R_W-1:0] scale_q12(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [SUM_W-1:0] s;
        s = SUM_W'(a) + (SUM_W'(b) <<< FRAC_BITS);
        return R_W'(s >>> FRAC_BITS);
    endfunction

    // Optional ReLU, then clamp to the Q6.6 range; ovf flags a clamp that changed the value.
    function automatic result_t relu_sat(
        input logic signed [R_W-1:0] r_in,
        input logic                  relu
    );
        logic signed [R_W-1:0] r;
        result_t               o;
        r     = (relu && (r_in < 0)) ? '0 : r_in;
        o.ovf = 1'b0;
        o.val = r[DATA_W-1:0];
        if (r > R_MAX) begin
            o.val = R_MAX[DATA_W-1:0];
            o.ovf = 1'b1;
        end else if (r < R_MIN) begin
            o.val = R_MIN[DATA_W-1:0];
            o.ovf = 1'b1;
        end
        return o;
    endfunction

    assign n_clamp    = (n_taps > 5'(MAX_TAPS)) ? 5'(MAX_TAPS) : n_taps;
    assign start_acc  = (state == IDLE) && ap_start;
    assign last_drain = (state == DRAIN) && drain_cnt;

    // Stage p0: address issue, tap k in cycle 1+k.
    assign vld_p0     = (state == FETCH);
    assign x_ce0      = vld_p0;
    assign w_ce0      = vld_p0;
    assign x_address0 = vld_p0 ? tap_cnt : '0;
    assign w_address0 = vld_p0 ? tap_cnt : '0;

    // Stage p1 -> p2: memory data valid, product registered at the end of the cycle.
    cnn_mac_mul_12s_7s u_mul (
        .clk (ap_clk),
        .a   (x_q0),
        .b   (w_q0),
        .p   (prod_p2)
    );

    // Stage p2 -> accumulator; result computed from the value about to be stored.
    assign acc_nxt = vld_p2 ? (acc + ACC_W'(prod_p2)) : acc;
    assign res     = relu_sat(scale_q12(acc_nxt, bias_r), relu_r);

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = (n_clamp == 5'd0) ? DRAIN : FETCH;
            end
            FETCH: if (tap_cnt == (n_eff_r - 5'd1)) state_nxt = DRAIN;
            DRAIN: if (drain_cnt) state_nxt = OUT;
            OUT: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, tap and drain counters, valid pipeline, tap count.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            drain_cnt <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            n_eff_r   <= '0;
        end else begin
            state     <= state_nxt;
            tap_cnt   <= (state == FETCH) ? (tap_cnt + 5'd1) : 5'd0;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            if (start_acc) n_eff_r <= n_clamp;
        end
    end

    // Per-operation settings captured at start.
    always_ff @(posedge ap_clk) begin
        if (start_acc) begin
            relu_r <= relu_en;
            bias_r <= bias;
        end
    end

    // Accumulator, cleared at every start.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)      acc <= '0;
        else if (start_acc) acc <= '0;
        else                acc <= acc_nxt;
    end

    // Output register, loaded on entry to OUT and held until the next operation's OUT.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_return <= '0;
            ovf       <= 1'b0;
        end else if (last_drain) begin
            ap_return <= res.val;
            ovf       <= res.ovf;
        end
    end

endmodule

// File: tb/tb_cnn_mac_seq.sv
// Scoreboard bench for cnn_mac_seq with latency-1 pixel and weight memory models.
module tb_cnn_mac_seq;

    typedef struct {
        logic signed [11:0] ret;
        bit                 ovf;
        int                 lat;
        int                 reads;
    } exp_t;

    logic               clk;
    logic               ap_rst_n;
    logic               ap_start;
    logic               ap_done, ap_idle, ap_ready;
    logic [4:0]         n_taps;
    logic               relu_en;
    logic signed [11:0] bias;
    logic [4:0]         x_address0, w_address0;
    logic               x_ce0, w_ce0;
    logic signed [11:0] x_q0;
    logic signed [6:0]  w_q0;
    logic signed [11:0] ap_return;
    logic               ovf;

    logic signed [11:0] xmem [32];
    logic signed [6:0]  wmem [32];

    exp_t sb[$];
    exp_t e;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   rd_cnt    = 0;
    int   idle_cnt  = 0;
    int   last_done = 0;
    int   prev_done = 0;

    cnn_mac_seq dut (
        .ap_clk     (clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .n_taps     (n_taps),
        .relu_en    (relu_en),
        .bias       (bias),
        .x_address0 (x_address0),
        .x_ce0      (x_ce0),
        .x_q0       (x_q0),
        .w_address0 (w_address0),
        .w_ce0      (w_ce0),
        .w_q0       (w_q0),
        .ap_return  (ap_return),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (x_ce0) x_q0 <= xmem[x_address0];
        if (w_ce0) w_q0 <= wmem[w_address0];
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int n, input bit relu, input int b);
        exp_t   r;
        longint acc, s, v;
        int     ne;
        ne  = (n > 25) ? 25 : n;
        acc = 0;
        for (int k = 0; k < ne; k++) acc += longint'(xmem[k]) * longint'(wmem[k]);
        s = acc + longint'(b) * 64;
        if (s >= 0) v = s / 64;
        else        v = -((-s + 63) / 64);
        if (relu && v < 0) v = 0;
        r.ovf = 1'b0;
        if (v > 2047)  begin v = 2047;  r.ovf = 1'b1; end
        if (v < -2048) begin v = -2048; r.ovf = 1'b1; end
        r.ret   = 12'(v);
        r.lat   = ne + 3;
        r.reads = ne;
        return r;
    endfunction

    task automatic fill_const(input int xv, input int wv);
        for (int k = 0; k < 32; k++) begin
            xmem[k] = 12'(xv);
            wmem[k] = 7'(wv);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 32; k++) begin
            xmem[k] = 12'($urandom);
            wmem[k] = 7'($urandom);
        end
    endtask

    task automatic launch(input int n, input bit relu, input int b, input bit expect_it);
        @(posedge clk); #1;
        if (expect_it) sb.push_back(model(n, relu, b));
        n_taps   = 5'(n);
        relu_en  = relu;
        bias     = 12'(b);
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check_eq("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_idle"},   ap_idle, 1);
        check_eq({tag, "_done"},   ap_done, 0);
        check_eq({tag, "_ready"},  ap_ready, 0);
        check_eq({tag, "_xce"},    x_ce0, 0);
        check_eq({tag, "_wce"},    w_ce0, 0);
        check_eq({tag, "_xaddr"},  x_address0, 0);
        check_eq({tag, "_waddr"},  w_address0, 0);
        check_eq({tag, "_return"}, ap_return, 0);
        check_eq({tag, "_ovf"},    ovf, 0);
    endtask

    // Output monitor: memory-port protocol every cycle, scoreboard pop on ap_done.
    always @(negedge clk) begin
        if (!ap_rst_n) begin
            rd_cnt = 0;
        end else begin
            check_eq("ready_eq_done", ap_ready, ap_done);
            if (x_ce0) begin
                check_eq("w_ce_on", w_ce0, 1);
                check_eq("w_addr", w_address0, x_address0);
                check_eq("x_addr", x_address0, rd_cnt);
                rd_cnt++;
            end else begin
                check_eq("w_ce_off", w_ce0, 0);
                check_eq("x_addr_off", x_address0, 0);
                check_eq("w_addr_off", w_address0, 0);
            end
            if (ap_idle) idle_cnt++;
            if (ap_done) begin
                check_eq("idle_in_out", ap_idle, 0);
                if (sb.size() == 0) begin
                    check_eq("spurious_done", ap_done, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("ap_return", ap_return, e.ret);
                    check_eq("ovf", ovf, e.ovf);
                    check_eq("done_cycle", cyc - start_cyc, e.lat);
                    check_eq("reads", rd_cnt, e.reads);
                end
                rd_cnt    = 0;
                prev_done = last_done;
                last_done = cyc;
            end
            if (ap_start && ap_idle) start_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        n_taps   = '0;
        relu_en  = 1'b0;
        bias     = '0;
        fill_const(0, 0);
        #1;
        check_reset_outs("por");
        repeat (3) @(posedge clk);
        #1 ap_rst_n = 1'b1;

        // Single tap: 1.0 * 0.5 = 0.5 -> 32
        fill_const(64, 32);
        launch(1, 0, 0, 1); wait_done();

        // Nine taps of 1.0 * -1.0 -> -9.0, then with ReLU -> 0
        fill_const(64, -64);
        launch(9, 0, 0, 1); wait_done();
        launch(9, 1, 0, 1); wait_done();

        // Positive saturation, then clamped tap count
        fill_const(2047, 63);
        launch(25, 0, 0, 1); wait_done();
        launch(31, 0, 0, 1); wait_done();

        // Zero taps: bias only, no memory reads
        launch(0, 0, 100, 1); wait_done();

        // Random operations
        for (int i = 0; i < 8; i++) begin
            fill_rand();
            launch(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 4095)) - 2048, 1);
            wait_done();
        end

        // Negative saturation
        fill_const(2047, -64);
        launch(25, 0, 0, 1); wait_done();

        // Reset in cycle 5 of a 25-tap operation
        launch(25, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1 ap_rst_n = 1'b0;
        #1 check_reset_outs("midop");
        repeat (2) @(posedge clk);
        #1 ap_rst_n = 1'b1;
        fill_const(64, 32);
        launch(1, 0, 0, 1); wait_done();

        // ap_start held high across two back-to-back 4-tap operations
        fill_rand();
        @(posedge clk); #1;
        sb.push_back(model(4, 0, 5));
        sb.push_back(model(4, 0, 5));
        n_taps   = 5'd4;
        relu_en  = 1'b0;
        bias     = 12'sd5;
        ap_start = 1'b1;
        idle_cnt = 0;
        begin
            int t;
            t = 0;
            while (sb.size() > 1 && t < 100) begin
                @(posedge clk);
                t++;
            end
        end
        @(posedge clk); #1;
        ap_start = 1'b0;
        wait_done();
        check_eq("done_spacing", last_done - prev_done, 8);
        check_eq("idle_cycles", idle_cnt, 2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cnn_mac_seq.md
CNN_MAC_SEQ -- requirements
Module: cnn_mac_seq

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 25, giving the maximum kernel taps per operation (5x5).
REQ-002 SHALL have parameter ACC_W, default 26, giving the accumulator width in bits, signed.
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports ap_start (input), and ap_done, ap_idle, ap_ready (outputs), 1 bit each: block-level start/done handshake.
REQ-006 SHALL have port n_taps, input, 5 bits: tap count, sampled at start.
REQ-007 SHALL have ports relu_en (input, 1 bit) and bias (input, 12 bits signed Q6.6), both sampled at start.
REQ-008 SHALL have ports x_address0 (output, 5 bits), x_ce0 (output, 1 bit) and x_q0 (input, 12 bits signed Q6.6): pixel memory, read latency 1.
REQ-009 SHALL have ports w_address0 (output, 5 bits), w_ce0 (output, 1 bit) and w_q0 (input, 7 bits signed Q1.6): weight memory, read latency 1.
REQ-010 SHALL have port ap_return, output, 12 bits signed Q6.6: the result.
REQ-011 SHALL have port ovf, output, 1 bit: saturation occurred in the last operation.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, DRAIN, OUT; IDLE->FETCH on ap_start=1; FETCH->DRAIN after the last address; DRAIN->OUT when the last product is accumulated; OUT->IDLE unconditionally.
REQ-013 SHALL clamp n_taps to MAX_TAPS when it exceeds MAX_TAPS; n_taps=0 SHALL go IDLE->DRAIN with no memory reads.
REQ-014 Timing, with start sampled in cycle 0: tap k address (x and w alike, k=0..N-1) issued in cycle 1+k with ce=1; q valid in cycle 2+k; product registered at end of cycle 2+k; accumulated in cycle 3+k.
REQ-015 SHALL deassert ce and hold addresses at 0 outside FETCH.
REQ-016 SHALL pulse ap_done and ap_ready together for exactly one cycle in OUT, at cycle N+3 (cycle 3 for N=0).
REQ-017 SHALL have no overlap: ap_start is ignored outside IDLE; ap_idle=1 only in IDLE.
REQ-018 If ap_start is held high, SHALL start the next operation in the cycle after ap_done.
REQ-019 Arithmetic: product SHALL be x*w, 20-bit signed Q.12; acc SHALL be cleared at start and sum the products at ACC_W bits with no internal overflow.
REQ-020 Result: s = acc + (bias<<<6); r = s>>>6 (arithmetic shift, floor); if relu_en and r<0 then r=0; saturate r to [-2048, 2047].
REQ-021 SHALL set ovf=1 iff saturation changed r, updated in OUT.
REQ-022 ap_return and ovf SHALL be registered, update only in OUT, and hold until the next OUT.

Reset
REQ-023 ap_rst_n=0 SHALL immediately force state IDLE, ap_idle=1, ap_done=ap_ready=0, ce=0, addresses=0, acc=0, ap_return=0, ovf=0.
REQ-024 Reset mid-operation SHALL abort it with no ap_done; the first start after release SHALL behave as from power-up.

Structure
REQ-025 A shared package SHALL hold the Q-format constants (FRAC_BITS=6, DATA_W=12, WGT_W=7, PROD_W=20), MAX_TAPS and the FSM state enum.
REQ-026 SHALL instantiate one sub-module, cnn_mac_mul_12s_7s: a registered signed 12x7->20 multiplier, latency 1, DSP-mapped.
REQ-027 Sequencing, accumulation and output stage SHALL stay in cnn_mac_seq.

Verification
REQ-028 n_taps=1, x=64, w=32, bias=0 -> ap_return=32, ovf=0, ap_done in cycle 4.
REQ-029 n_taps=9, all x=64, w=-64, relu_en=0 -> ap_return=-576, done in cycle 12; repeat with relu_en=1 -> 0.
REQ-030 n_taps=25, all x=2047, w=63 -> ap_return=2047, ovf=1; n_taps=31 -> same result (clamped), 25 reads seen.
REQ-031 n_taps=0, bias=100 -> ap_return=100, x_ce0 and w_ce0 never asserted, done in cycle 3.
REQ-032 Assert ap_rst_n=0 in cycle 5 of a 25-tap operation -> all outputs at reset values, no ap_done; next operation with n_taps=1 (x=64, w=32) -> 32.
REQ-033 ap_start held high across two 4-tap operations -> second ap_done exactly 8 cycles after the first; ap_idle=1 only in cycles 0 and 8.
